regfile_rename: RTL
===================

# regfile_rename

Architectural register file plus rename map for the out-of-order RISC-V core: holds committed values and, per register, a busy bit and the ROB tag of its latest in-flight producer. Sits between the instruction queue (source lookup, destination rename), the ROB (commit write-back) and branch recovery. It commits on up to NCOMMIT ports per cycle, clears busy by tag match, forwards same-cycle commits to source reads, and holds NCKPT rename-map checkpoints for single-cycle misprediction recovery.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural registers; AW = clog2(NREG)
- TAG_W, 4, ROB tag width
- NCOMMIT, 2, commit ports; higher index = younger
- NCKPT, 4, checkpoint slots; CW = clog2(NCKPT)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- flush_all  in  1  clear every busy bit, invalidate all checkpoints
- rs1_addr, rs2_addr  in  AW  source lookups
- rs1_busy, rs2_busy  out  1  source awaits a producer
- rs1_tag, rs2_tag  out  TAG_W  producer ROB tag
- rs1_val, rs2_val  out  XLEN  committed value
- ren_valid  in  1  rename destination this cycle
- ren_rd  in  AW  destination register
- ren_tag  in  TAG_W  ROB tag of renaming instruction
- cm_valid  in  NCOMMIT  per-port commit strobe
- cm_rd  in  NCOMMIT*AW  committed destination
- cm_tag  in  NCOMMIT*TAG_W  committed ROB tag
- cm_val  in  NCOMMIT*XLEN  committed value
- ck_save  in  1  snapshot the map into slot ck_save_id
- ck_save_id  in  CW
- ck_free  in  1  release slot ck_free_id (branch resolved correctly)
- ck_free_id  in  CW
- ck_restore  in  1  restore map from slot ck_restore_id (mispredict)
- ck_restore_id  in  CW
- ck_valid  out  NCKPT  slot occupancy
- ck_err  out  1  sticky: restore of invalid slot, or save to valid slot

## Operation
- x0: reads val 0, busy 0, tag 0; rename/commit to x0 ignored.
- Reads combinational from current state plus commit forwarding: if some port commits rs with cm_tag equal to the stored tag of a busy rs, output busy 0 and that port's cm_val; youngest matching port wins. Same-cycle rename not reflected (source precedes its own destination).
- Commit port p (ascending p): val[rd] <= cm_val; busy[rd] cleared only if busy and tag[rd] == cm_tag. Same-register ports: youngest value wins.
- Rename: busy[rd] <= 1, tag[rd] <= ren_tag; overrides any same-cycle busy clear for that register.
- Every commit also clears busy for matching (rd, tag) inside every valid checkpoint image.
- ck_save: image = busy/tag map after this cycle's rename and commits; ck_valid[id] <= 1. Saving into a valid slot overwrites and sets ck_err.
- ck_free: ck_valid[id] <= 0; free and save of same id in one cycle: save wins.
- ck_restore (valid slot): live busy/tag <= slot image with same-cycle commit clears applied; values unaffected; rename and ck_save that cycle dropped; ck_valid cleared for the restored slot and all younger slots (allocation order tracked by an internal NCKPT-entry age queue). Invalid slot: no change, ck_err set.
- flush_all: busy all 0, ck_valid all 0; same-cycle commit values still written; rename/save/restore dropped.
- Priority: rst > ~rdy > flush_all > ck_restore > normal.

## Timing
- Reset: all val 0, busy 0, tag 0, ck_valid 0, ck_err 0; read outputs accordingly.
- Read latency 0 (combinational); all updates visible the cycle after the edge.
- Restore/flush single-cycle; reads during that cycle show pre-restore state.
- rdy low: no update, ck_err holds, reads still valid; held inputs are re-sampled when rdy returns.
- rst mid-operation discards all checkpoints.

## Test plan
- Reset, read x5 -> busy 0, tag 0, val 0; ck_valid 0.
- Rename x5 tag 3; next cycle commit x5 tag 3 val 0xABCD -> in commit cycle rs1=x5 reads busy 0, val 0xABCD; next cycle busy 0.
- Rename x5 tag 3, then tag 7; commit tag 3 val 1 -> val 1 stored, busy 1, tag 7 retained.
- Same cycle: commit x6 tag 2 and rename x6 tag 9 -> busy 1, tag 9, val updated.
- Port 0 and port 1 commit x7 vals 0x11/0x22, tag of port 1 matches -> val 0x22, busy 0.
- Save slot 1 with x8 busy tag 4; rename x8 tag 5; commit tag 4; restore slot 1 -> x8 busy 0; restore slot 2 (invalid) -> ck_err 1.

Source files
------------

// File: rtl/regfile_rename.sv
// rtl/regfile_rename.sv - architectural register file with busy/tag rename map,
// commit forwarding and checkpointed map recovery.
module regfile_rename #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int TAG_W   = 4,
  parameter int NCOMMIT = 2,
  parameter int NCKPT   = 4,
  localparam int AW     = $clog2(NREG),
  localparam int CW     = $clog2(NCKPT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush_all,
  input  logic [AW-1:0]            rs1_addr,
  input  logic [AW-1:0]            rs2_addr,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic [TAG_W-1:0]         rs1_tag,
  output logic [TAG_W-1:0]         rs2_tag,
  output logic [XLEN-1:0]          rs1_val,
  output logic [XLEN-1:0]          rs2_val,
  input  logic                     ren_valid,
  input  logic [AW-1:0]            ren_rd,
  input  logic [TAG_W-1:0]         ren_tag,
  input  logic [NCOMMIT-1:0]       cm_valid,
  input  logic [NCOMMIT*AW-1:0]    cm_rd,
  input  logic [NCOMMIT*TAG_W-1:0] cm_tag,
  input  logic [NCOMMIT*XLEN-1:0]  cm_val,
  input  logic                     ck_save,
  input  logic [CW-1:0]            ck_save_id,
  input  logic                     ck_free,
  input  logic [CW-1:0]            ck_free_id,
  input  logic                     ck_restore,
  input  logic [CW-1:0]            ck_restore_id,
  output logic [NCKPT-1:0]         ck_valid,
  output logic                     ck_err
);

  logic [XLEN-1:0]  val_q   [NREG];
  logic [XLEN-1:0]  val_d   [NREG];
  logic [NREG-1:0]  busy_q, busy_c, busy_d, busy_n;
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [TAG_W-1:0] tag_d   [NREG];
  logic [TAG_W-1:0] tag_n   [NREG];

  logic [NREG-1:0]  ck_busy_q [NCKPT];
  logic [NREG-1:0]  ckc_busy  [NCKPT];
  logic [NREG-1:0]  ck_busy_d [NCKPT];
  logic [TAG_W-1:0] ck_tag_q  [NCKPT][NREG];
  logic [TAG_W-1:0] ck_tag_d  [NCKPT][NREG];
  logic [NCKPT-1:0] ck_valid_q, ck_valid_d;
  // younger_q[i][j] set means slot j was allocated after slot i
  logic [NCKPT-1:0] younger_q [NCKPT];
  logic [NCKPT-1:0] younger_d [NCKPT];
  logic             ck_err_q, ck_err_d;

  logic [AW-1:0]      c_rd  [NCOMMIT];
  logic [TAG_W-1:0]   c_tag [NCOMMIT];
  logic [XLEN-1:0]    c_val [NCOMMIT];
  logic [NCOMMIT-1:0] c_en;
  logic               ren_en;
  logic               restore_ok;

  always_comb begin
    for (int p = 0; p < NCOMMIT; p++) begin
      c_rd[p]  = cm_rd[p*AW +: AW];
      c_tag[p] = cm_tag[p*TAG_W +: TAG_W];
      c_val[p] = cm_val[p*XLEN +: XLEN];
      c_en[p]  = cm_valid[p] && (c_rd[p] != '0);
    end
  end

  assign ren_en     = ren_valid && (ren_rd != '0);
  assign restore_ok = ck_valid_q[ck_restore_id];

  // Source reads: a same-cycle commit of the awaited producer is forwarded.
  logic [AW-1:0]    r_addr [2];
  logic             r_busy [2];
  logic [TAG_W-1:0] r_tag  [2];
  logic [XLEN-1:0]  r_val  [2];

  assign r_addr[0] = rs1_addr;
  assign r_addr[1] = rs2_addr;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      r_busy[s] = busy_q[r_addr[s]];
      r_tag[s]  = tag_q[r_addr[s]];
      r_val[s]  = val_q[r_addr[s]];
      for (int p = 0; p < NCOMMIT; p++) begin
        if (c_en[p] && c_rd[p] == r_addr[s] && busy_q[r_addr[s]] &&
            c_tag[p] == tag_q[r_addr[s]]) begin
          r_busy[s] = 1'b0;
          r_val[s]  = c_val[p];
        end
      end
    end
  end

  assign rs1_busy = r_busy[0];
  assign rs1_tag  = r_tag[0];
  assign rs1_val  = r_val[0];
  assign rs2_busy = r_busy[1];
  assign rs2_tag  = r_tag[1];
  assign rs2_val  = r_val[1];
  assign ck_valid = ck_valid_q;
  assign ck_err   = ck_err_q;

  // Live map and values after commits, then rename on top.
  always_comb begin
    val_d  = val_q;
    busy_c = busy_q;
    for (int p = 0; p < NCOMMIT; p++) begin
      if (c_en[p]) begin
        val_d[c_rd[p]] = c_val[p];
        if (busy_q[c_rd[p]] && tag_q[c_rd[p]] == c_tag[p]) busy_c[c_rd[p]] = 1'b0;
      end
    end
    busy_d = busy_c;
    tag_d  = tag_q;
    if (ren_en) begin
      busy_d[ren_rd] = 1'b1;
      tag_d[ren_rd]  = ren_tag;
    end
  end

  // Commits also retire matching producers inside every checkpoint image.
  always_comb begin
    for (int k = 0; k < NCKPT; k++) begin
      ckc_busy[k] = ck_busy_q[k];
      for (int p = 0; p < NCOMMIT; p++) begin
        if (c_en[p] && ck_busy_q[k][c_rd[p]] && ck_tag_q[k][c_rd[p]] == c_tag[p])
          ckc_busy[k][c_rd[p]] = 1'b0;
      end
    end
  end

  always_comb begin
    busy_n     = busy_d;
    tag_n      = tag_d;
    ck_busy_d  = ckc_busy;
    ck_tag_d   = ck_tag_q;
    ck_valid_d = ck_valid_q;
    younger_d  = younger_q;
    ck_err_d   = ck_err_q;
    if (flush_all) begin
      busy_n     = '0;
      tag_n      = tag_q;
      ck_valid_d = '0;
    end else if (ck_restore) begin
      if (ck_free) ck_valid_d[ck_free_id] = 1'b0;
      if (restore_ok) begin
        busy_n     = ckc_busy[ck_restore_id];
        tag_n      = ck_tag_q[ck_restore_id];
        ck_valid_d = ck_valid_d & ~younger_q[ck_restore_id]
                     & ~(NCKPT'(1) << ck_restore_id);
      end else begin
        busy_n   = busy_c;
        tag_n    = tag_q;
        ck_err_d = 1'b1;
      end
    end else begin
      if (ck_free) ck_valid_d[ck_free_id] = 1'b0;
      if (ck_save) begin
        ck_busy_d[ck_save_id]  = busy_d;
        ck_tag_d[ck_save_id]   = tag_d;
        ck_valid_d[ck_save_id] = 1'b1;
        if (ck_valid_q[ck_save_id]) ck_err_d = 1'b1;
        for (int i = 0; i < NCKPT; i++) younger_d[i][ck_save_id] = 1'b1;
        younger_d[ck_save_id] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      busy_q <= '0;
      for (int k = 0; k < NCKPT; k++) begin
        ck_busy_q[k] <= '0;
        younger_q[k] <= '0;
        for (int r = 0; r < NREG; r++) ck_tag_q[k][r] <= '0;
      end
      ck_valid_q <= '0;
      ck_err_q   <= 1'b0;
    end else if (rdy) begin
      val_q      <= val_d;
      busy_q     <= busy_n;
      tag_q      <= tag_n;
      ck_busy_q  <= ck_busy_d;
      ck_tag_q   <= ck_tag_d;
      ck_valid_q <= ck_valid_d;
      younger_q  <= younger_d;
      ck_err_q   <= ck_err_d;
    end
  end

endmodule
